data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Memory-stage load/store controller for the mipsel32 pipeline. Accepts one memory operation from EX and drives the SRAM-like data port with size, byte strobes and lane-aligned write data, including the partial-word SWL/SWR encodings. Returns the raw read word plus byte offset and RT value so the downstream LWL/LWR merge stage can combine them. Also returns the extended result for ordinary loads. Handles one outstanding transaction, exception flush, and alignment faults.

## Interface
- `store_lr`, default 1: 1 = SWL/SWR supported; 0 = those ops treated as no-op stores with strobe 0000.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: exception/ERET cancel of the in-flight operation.
- `ex_valid` in 1, `ex_ready` out 1: EX→MEM handshake; accept when both are high.
- `ex_op` in 4: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; others are no-op.
- `ex_addr` in 32: effective address.
- `ex_rt` in 32: RT value, used as store data and merge register word.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr` out 32, `data_wstrb` out 4, `data_wdata` out 32: request port.
- `data_addr_ok` in 1, `data_data_ok` in 1, `data_rdata` in 32: memory responses.
- `wb_valid` out 1, `wb_ready` in 1: MEM→WB handshake.
- `wb_op` out 4: captured op.
- `wb_byte_addr` out 2: captured `ex_addr[1:0]`.
- `wb_reg_word` out 32: captured `ex_rt`.
- `wb_mem_word` out 32: raw `data_rdata`.
- `wb_result` out 32: extended load result.
- `wb_adel` out 1, `wb_ades` out 1: alignment fault on load / on store.
- `wb_badvaddr` out 32: faulting address.

## Operation
- States: IDLE, REQ, WAIT, CANCEL, DONE. `ex_ready` = (state==IDLE).
- **IDLE, on accept:**
  - Register op, address and RT.
  - Misaligned LH/LHU/SH (a[0]) or LW/SW (a[1:0]≠0) → DONE with adel (loads) or ades (stores) set. No memory request is made.
  - No-op opcode → DONE with no request.
  - Otherwise → REQ.
- **REQ:**
  - `data_req`=1; all request outputs are driven from registers and stay stable until `data_addr_ok`.
  - On `data_addr_ok` → WAIT.
  - `flush` before `data_addr_ok` → IDLE, with `data_req` low the next cycle.
- **WAIT:**
  - On `data_data_ok` → DONE, capturing `data_rdata`.
  - `flush` → CANCEL.
- **CANCEL:** on `data_data_ok` → IDLE; the data is discarded and `wb_valid` is never raised.
- **DONE:**
  - `wb_valid`=1; on `wb_ready` → IDLE.
  - `flush` → IDLE with `wb_valid` dropped.
- Flush in IDLE: nothing is accepted that cycle.
- **Request encoding** (a = addr[1:0]):
  - SB/LB/LBU: size 0; strobe 1<<a; wdata = {4{rt[7:0]}}.
  - SH/LH/LHU: size 1; strobe 0011 (a=0) or 1100 (a=2); wdata = {2{rt[15:0]}}.
  - SW/LW: size 2; strobe 1111; wdata = rt.
  - LWL/LWR/SWL/SWR: `data_addr` = {addr[31:2],2'b00}; size 2.
  - SWL: strobe = bytes 0..a (0001, 0011, 0111, 1111); wdata = rt >> 8·(3−a).
  - SWR: strobe = bytes a..3 (1111, 1110, 1100, 1000); wdata = rt << 8·a.
  - Loads: `data_wr`=0, strobe 0000. Stores: `data_wr`=1.
- **`wb_result`:**
  - LB/LBU: sign-/zero-extend byte lane a.
  - LH/LHU: sign-/zero-extend half lane a[1].
  - LW/LWL/LWR: raw word; the merge stage finishes LWL/LWR.
  - Stores and faults: 0.

## Timing
- Reset: state IDLE. `ex_ready`=1; `data_req`=0, `data_wr`=0, `data_wstrb`=0. `wb_valid`=0, `wb_adel`=0, `wb_ades`=0. All data outputs 0.
- Accept at cycle T → `data_req` at T+1.
- With `data_addr_ok` at T+1 and `data_data_ok` at T+2, `wb_valid` is high at T+3. That is minimum load/store latency 3.
- Fault path: `wb_valid` at T+1.
- `data_data_ok` is never sampled in the same cycle as the `data_addr_ok` of the same request.
- `wb_*` outputs are held stable while `wb_valid` and not `wb_ready`.
- Back-to-back operation: accept requires IDLE, so one operation every 4 cycles at best.
- `flush` has priority over every other event in the same cycle, including simultaneous `data_data_ok` in WAIT, which goes to IDLE directly.
- `reset` mid-transaction → IDLE. A pending `data_data_ok` after reset is ignored in IDLE.

## Test plan
- **LB:** LB addr 0x1003, rdata 0x80FF_1234, addr_ok T+1, data_ok T+2 → size 0, strobe 0000, `wb_result` 0xFFFF_FF80 at T+3, `wb_byte_addr` 3.
- **SWL/SWR:** SWL addr 0x2001, rt 0xAABB_CCDD → `data_addr` 0x2000, strobe 0011, wdata 0x0000_AABB. SWR addr 0x2002, same rt → strobe 1100, wdata 0xCCDD_0000.
- **Misaligned load:** LW addr 0x3002 → no `data_req` ever; `wb_valid` at T+1 with `wb_adel`=1, `wb_badvaddr` 0x3002.
- **Flush in WAIT:** `flush` in WAIT, data_ok 5 cycles later → `wb_valid` stays 0; `ex_ready` returns the cycle after data_ok. The next LW then completes normally.
- **Backpressure:** `addr_ok` delayed 4 cycles → req/addr/strobe stable throughout. With `wb_ready`=0 for 3 cycles in DONE, `wb_*` are held; `ex_ready` stays 0 until the handshake.
- **Reset:** `reset` asserted in REQ → next cycle `data_req`=0, `ex_ready`=1, `wb_valid`=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: memory-stage load/store controller for the mipsel32 pipeline.
// Accepts one op from EX, drives the data port with size/strobe/lane-aligned
// write data (including SWL/SWR), and hands the raw word, byte offset, RT
// value and extended load result to WB. One transaction outstanding at a time.
module data_mem_ctrl #(
  parameter bit store_lr = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_rt,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_op,
  output logic [1:0]  wb_byte_addr,
  output logic [31:0] wb_reg_word,
  output logic [31:0] wb_mem_word,
  output logic [31:0] wb_result,
  output logic        wb_adel,
  output logic        wb_ades,
  output logic [31:0] wb_badvaddr
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CANCEL,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_data_req;
  logic        r_data_wr;
  logic [1:0]  r_data_size;
  logic [31:0] r_data_addr;
  logic [3:0]  r_data_wstrb;
  logic [31:0] r_data_wdata;
  logic        r_wb_valid;
  logic [3:0]  r_wb_op;
  logic [1:0]  r_wb_byte_addr;
  logic [31:0] r_wb_reg_word;
  logic [31:0] r_wb_mem_word;
  logic [31:0] r_wb_result;
  logic        r_wb_adel;
  logic        r_wb_ades;
  logic [31:0] r_wb_badvaddr;

  logic [1:0]  w_a;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_result;

  assign w_a = ex_addr[1:0];

  // Decode the incoming EX op into its request encoding and fault status.
  always_comb begin
    w_is_load  = (ex_op <= OP_LWR);
    w_is_store = (ex_op >= OP_SB) && (ex_op <= OP_SWR);
    w_misalign = 1'b0;
    w_size     = 2'd2;
    w_addr     = ex_addr;
    w_strb     = '0;
    w_wdata    = '0;
    case (ex_op)
      OP_LB, OP_LBU, OP_SB: begin
        w_size  = 2'd0;
        w_wdata = {4{ex_rt[7:0]}};
        if (ex_op == OP_SB) w_strb = 4'b0001 << w_a;
      end
      OP_LH, OP_LHU, OP_SH: begin
        w_size     = 2'd1;
        w_wdata    = {2{ex_rt[15:0]}};
        w_misalign = w_a[0];
        if (ex_op == OP_SH) w_strb = w_a[1] ? 4'b1100 : 4'b0011;
      end
      OP_LW, OP_SW: begin
        w_wdata    = ex_rt;
        w_misalign = (w_a != 2'd0);
        if (ex_op == OP_SW) w_strb = 4'b1111;
      end
      OP_LWL, OP_LWR: begin
        w_addr = {ex_addr[31:2], 2'b00};
      end
      OP_SWL: begin
        w_addr  = {ex_addr[31:2], 2'b00};
        w_wdata = ex_rt >> {(2'd3 - w_a), 3'b000};
        if (store_lr) w_strb = 4'b1111 >> (2'd3 - w_a);
      end
      OP_SWR: begin
        w_addr  = {ex_addr[31:2], 2'b00};
        w_wdata = ex_rt << {w_a, 3'b000};
        if (store_lr) w_strb = 4'b1111 << w_a;
      end
      default: ;
    endcase
  end

  // Extend the returned word according to the captured op and byte offset.
  always_comb begin
    w_shifted = data_rdata >> {r_wb_byte_addr, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = r_wb_byte_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    w_result  = '0;
    case (r_wb_op)
      OP_LB:                 w_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:                w_result = {24'd0, w_byte};
      OP_LH:                 w_result = {{16{w_half[15]}}, w_half};
      OP_LHU:                w_result = {16'd0, w_half};
      OP_LW, OP_LWL, OP_LWR: w_result = data_rdata;
      default:               w_result = '0;
    endcase
  end

  // Control FSM with registered request and writeback outputs; flush wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_data_req     <= 1'b0;
      r_data_wr      <= 1'b0;
      r_data_size    <= '0;
      r_data_addr    <= '0;
      r_data_wstrb   <= '0;
      r_data_wdata   <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_op        <= '0;
      r_wb_byte_addr <= '0;
      r_wb_reg_word  <= '0;
      r_wb_mem_word  <= '0;
      r_wb_result    <= '0;
      r_wb_adel      <= 1'b0;
      r_wb_ades      <= 1'b0;
      r_wb_badvaddr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_valid && !flush) begin
            r_wb_op        <= ex_op;
            r_wb_byte_addr <= w_a;
            r_wb_reg_word  <= ex_rt;
            r_wb_mem_word  <= '0;
            r_wb_result    <= '0;
            r_wb_adel      <= 1'b0;
            r_wb_ades      <= 1'b0;
            r_wb_badvaddr  <= '0;
            if (w_misalign) begin
              r_state       <= S_DONE;
              r_wb_valid    <= 1'b1;
              r_wb_adel     <= w_is_load;
              r_wb_ades     <= w_is_store;
              r_wb_badvaddr <= ex_addr;
            end else if (!w_is_load && !w_is_store) begin
              r_state    <= S_DONE;
              r_wb_valid <= 1'b1;
            end else begin
              r_state      <= S_REQ;
              r_data_req   <= 1'b1;
              r_data_wr    <= w_is_store;
              r_data_size  <= w_size;
              r_data_addr  <= w_addr;
              r_data_wstrb <= w_strb;
              r_data_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (flush || data_addr_ok) begin
            r_state      <= flush ? S_IDLE : S_WAIT;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_wstrb <= '0;
          end
        end
        S_WAIT: begin
          if (flush) begin
            // A response arriving with the flush is simply dropped.
            r_state <= data_data_ok ? S_IDLE : S_CANCEL;
          end else if (data_data_ok) begin
            r_state       <= S_DONE;
            r_wb_valid    <= 1'b1;
            r_wb_mem_word <= data_rdata;
            r_wb_result   <= w_result;
          end
        end
        S_CANCEL: begin
          if (data_data_ok) r_state <= S_IDLE;
        end
        S_DONE: begin
          if (flush || wb_ready) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready     = (r_state == S_IDLE);
  assign data_req     = r_data_req;
  assign data_wr      = r_data_wr;
  assign data_size    = r_data_size;
  assign data_addr    = r_data_addr;
  assign data_wstrb   = r_data_wstrb;
  assign data_wdata   = r_data_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_op        = r_wb_op;
  assign wb_byte_addr = r_wb_byte_addr;
  assign wb_reg_word  = r_wb_reg_word;
  assign wb_mem_word  = r_wb_mem_word;
  assign wb_result    = r_wb_result;
  assign wb_adel      = r_wb_adel;
  assign wb_ades      = r_wb_ades;
  assign wb_badvaddr  = r_wb_badvaddr;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: hand-computed expectations checked with
// immediate assertions; inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, ex_valid, ex_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr, ex_rt;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_op;
  logic [1:0]  wb_byte_addr;
  logic [31:0] wb_reg_word, wb_mem_word, wb_result;
  logic        wb_adel, wb_ades;
  logic [31:0] wb_badvaddr;

  int checks = 0;
  int errors = 0;

  data_mem_ctrl #(.store_lr(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_rt(ex_rt),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_op(wb_op),
    .wb_byte_addr(wb_byte_addr), .wb_reg_word(wb_reg_word),
    .wb_mem_word(wb_mem_word), .wb_result(wb_result),
    .wb_adel(wb_adel), .wb_ades(wb_ades), .wb_badvaddr(wb_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_addr  = addr;
    ex_rt    = rt;
    tick();
    ex_valid = 1'b0;
  endtask

  // Minimum-latency memory response: addr_ok next cycle, data_ok the one after.
  task automatic respond(input logic [31:0] rd);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rd;
    tick();
    data_data_ok = 1'b0;
  endtask

  task automatic ack();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0;
    ex_addr = '0; ex_rt = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    data_rdata = '0; wb_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_req", data_req, 0);
    chk("rst_wr", data_wr, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_adel", wb_adel, 0);
    chk("rst_ades", wb_ades, 0);
    chk("rst_result", wb_result, 0);

    // LB 0x1003, sign-extended lane 3
    issue(4'd0, 32'h0000_1003, 32'h1234_5678);
    chk("lb_req", data_req, 1);
    chk("lb_ready", ex_ready, 0);
    chk("lb_size", data_size, 0);
    chk("lb_strb", data_wstrb, 0);
    chk("lb_wr", data_wr, 0);
    chk("lb_addr", data_addr, 32'h0000_1003);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("lb_req_drop", data_req, 0);
    chk("lb_wait_valid", wb_valid, 0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h80FF_1234;
    tick();
    data_data_ok = 1'b0;
    chk("lb_valid", wb_valid, 1);
    chk("lb_result", wb_result, 32'hFFFF_FF80);
    chk("lb_byte_addr", wb_byte_addr, 3);
    chk("lb_mem_word", wb_mem_word, 32'h80FF_1234);
    chk("lb_reg_word", wb_reg_word, 32'h1234_5678);
    chk("lb_op", wb_op, 0);
    ack();
    chk("lb_ack_valid", wb_valid, 0);
    chk("lb_ack_ready", ex_ready, 1);

    // SWL 0x2001
    issue(4'd11, 32'h0000_2001, 32'hAABB_CCDD);
    chk("swl_req", data_req, 1);
    chk("swl_wr", data_wr, 1);
    chk("swl_size", data_size, 2);
    chk("swl_addr", data_addr, 32'h0000_2000);
    chk("swl_strb", data_wstrb, 4'b0011);
    chk("swl_wdata", data_wdata, 32'h0000_AABB);
    respond(32'h5555_5555);
    chk("swl_valid", wb_valid, 1);
    chk("swl_result", wb_result, 0);
    ack();

    // SWR 0x2002
    issue(4'd12, 32'h0000_2002, 32'hAABB_CCDD);
    chk("swr_addr", data_addr, 32'h0000_2000);
    chk("swr_strb", data_wstrb, 4'b1100);
    chk("swr_wdata", data_wdata, 32'hCCDD_0000);
    respond(32'h0);
    ack();

    // SB 0x2001: strobe lane 1, byte replicated
    issue(4'd8, 32'h0000_2001, 32'h0000_00A5);
    chk("sb_strb", data_wstrb, 4'b0010);
    chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    chk("sb_size", data_size, 0);
    respond(32'h0);
    ack();

    // Misaligned LW 0x3002
    issue(4'd4, 32'h0000_3002, 32'h0);
    chk("adel_req", data_req, 0);
    chk("adel_valid", wb_valid, 1);
    chk("adel_flag", wb_adel, 1);
    chk("adel_ades", wb_ades, 0);
    chk("adel_badv", wb_badvaddr, 32'h0000_3002);
    chk("adel_result", wb_result, 0);
    ack();
    chk("adel_after_req", data_req, 0);

    // Misaligned SH 0x3001, then flush in DONE
    issue(4'd9, 32'h0000_3001, 32'h0);
    chk("ades_flag", wb_ades, 1);
    chk("ades_adel", wb_adel, 0);
    chk("ades_badv", wb_badvaddr, 32'h0000_3001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("done_flush_valid", wb_valid, 0);
    chk("done_flush_ready", ex_ready, 1);

    // No-op opcode 7
    issue(4'd7, 32'h0000_0001, 32'h0);
    chk("noop_req", data_req, 0);
    chk("noop_valid", wb_valid, 1);
    chk("noop_adel", wb_adel, 0);
    ack();

    // Flush in WAIT, response 5 cycles later
    issue(4'd4, 32'h0000_4000, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("cancel_valid", wb_valid, 0);
      chk("cancel_ready", ex_ready, 0);
      tick();
    end
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_1111;
    tick();
    data_data_ok = 1'b0;
    chk("cancel_end_ready", ex_ready, 1);
    chk("cancel_end_valid", wb_valid, 0);
    issue(4'd4, 32'h0000_4004, 32'h0);
    respond(32'hDEAD_BEEF);
    chk("lw_after_valid", wb_valid, 1);
    chk("lw_after_result", wb_result, 32'hDEAD_BEEF);
    ack();

    // Flush together with data_ok in WAIT
    issue(4'd4, 32'h0000_8000, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    data_data_ok = 1'b1;
    tick();
    flush = 1'b0;
    data_data_ok = 1'b0;
    chk("flush_dok_ready", ex_ready, 1);
    chk("flush_dok_valid", wb_valid, 0);

    // Backpressure: SH with addr_ok held off 4 cycles, wb_ready off 3 cycles
    issue(4'd9, 32'h0000_5002, 32'h1234_ABCD);
    for (int i = 0; i < 4; i++) begin
      chk("bp_req", data_req, 1);
      chk("bp_addr", data_addr, 32'h0000_5002);
      chk("bp_strb", data_wstrb, 4'b1100);
      chk("bp_wdata", data_wdata, 32'hABCD_ABCD);
      chk("bp_size", data_size, 1);
      tick();
    end
    respond(32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_op", wb_op, 9);
      chk("bp_wb_reg", wb_reg_word, 32'h1234_ABCD);
      chk("bp_wb_byte", wb_byte_addr, 2);
      chk("bp_ex_ready", ex_ready, 0);
      tick();
    end
    ack();
    chk("bp_ack_ready", ex_ready, 1);

    // Halfword / unsigned byte extension
    issue(4'd2, 32'h0000_5002, 32'h0);
    respond(32'h8001_7FFF);
    chk("lh_result", wb_result, 32'hFFFF_8001);
    ack();
    issue(4'd3, 32'h0000_5000, 32'h0);
    respond(32'h8001_7FFF);
    chk("lhu_result", wb_result, 32'h0000_7FFF);
    ack();
    issue(4'd1, 32'h0000_6001, 32'h0);
    respond(32'h0000_9A00);
    chk("lbu_result", wb_result, 32'h0000_009A);
    ack();

    // LWL: aligned address, raw word returned
    issue(4'd5, 32'h0000_6003, 32'h0);
    chk("lwl_addr", data_addr, 32'h0000_6000);
    chk("lwl_size", data_size, 2);
    respond(32'h0102_0304);
    chk("lwl_result", wb_result, 32'h0102_0304);
    chk("lwl_byte", wb_byte_addr, 3);
    ack();

    // Flush in REQ
    issue(4'd4, 32'h0000_9000, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("req_flush_req", data_req, 0);
    chk("req_flush_ready", ex_ready, 1);

    // Flush in IDLE blocks accept
    flush = 1'b1;
    issue(4'd4, 32'h0000_9000, 32'h0);
    flush = 1'b0;
    chk("idle_flush_ready", ex_ready, 1);
    chk("idle_flush_req", data_req, 0);

    // Reset while in REQ, stale data_ok ignored
    issue(4'd4, 32'h0000_7000, 32'h0);
    chk("rreq_req", data_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rreq_req_after", data_req, 0);
    chk("rreq_ready", ex_ready, 1);
    chk("rreq_valid", wb_valid, 0);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("rreq_stale_ready", ex_ready, 1);
    chk("rreq_stale_valid", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
